flush_fifo: RTL

- Parametrised circular-buffer FIFO for the out-of-order core, e.g. between decode and rename, or as an issue/LSU staging queue.
- Provides show-ahead read data, an occupancy count and an almost-full flag for upstream stall.
- Provides a single-cycle flush for mispredict recovery, plus sticky overflow/underflow error flags.
- Generalises a plain enq/deq/full/empty FIFO to arbitrary width and depth, with these recovery and flow-control features added.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ptr.sv | 27 ++
 rtl/flush_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types: count-width helper, default count type and the status bundle
// reused by queue wrappers.
package fifo_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_DEPTH);

  typedef logic [DEFAULT_CNT_W-1:0] fifo_cnt_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit circular pointer: synchronous reset, clear (flush) has priority over increment.
module fifo_ptr #(
  parameter int unsigned PW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/flush_fifo.sv
// Show-ahead circular FIFO with single-cycle flush, almost-full and sticky error flags.
// Optional empty-FIFO bypass enabled by defining FLUSH_FIFO_BYPASS_EN.
module flush_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_SLACK   = 2,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  enq,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  deq,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("flush_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_SLACK >= DEPTH) begin : g_bad_slack
    $error("flush_fifo: AF_SLACK must be in 0..DEPTH-1");
  end
  if (ADDR_WIDTH != $clog2(DEPTH) || CNT_W != ADDR_WIDTH + 1) begin : g_bad_aw
    $error("flush_fifo: ADDR_WIDTH is derived from DEPTH and must not be overridden");
  end

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] head, tail;
  logic                full_c, empty_c, bypass_c;
  logic                enq_fire_c, deq_fire_c;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  fifo_status_t        status_c;

  fifo_ptr #(.PW(ADDR_WIDTH + 1)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (deq_fire_c),
    .ptr_o (head)
  );

  fifo_ptr #(.PW(ADDR_WIDTH + 1)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (enq_fire_c),
    .ptr_o (tail)
  );

  assign empty_c = (head == tail);
  assign full_c  = (head[ADDR_WIDTH-1:0] == tail[ADDR_WIDTH-1:0]) &&
                   (head[ADDR_WIDTH] != tail[ADDR_WIDTH]);

`ifdef FLUSH_FIFO_BYPASS_EN
  // Push and pop against an empty queue pass straight through without touching storage.
  assign bypass_c = empty_c & enq & deq & ~flush;
`else
  assign bypass_c = 1'b0;
`endif

  assign enq_fire_c = enq & ~full_c & ~flush & ~bypass_c;
  assign deq_fire_c = deq & ~empty_c & ~flush;

  always_ff @(posedge clk) begin
    if (enq_fire_c) mem[tail[ADDR_WIDTH-1:0]] <= data_in;
  end

  always_comb begin
    ovf_d = ovf_q | (enq & full_c & ~flush);
    unf_d = unf_q | (deq & empty_c & ~flush & ~bypass_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign count = tail - head;

  always_comb begin
    status_c             = '0;
    status_c.full        = full_c;
    status_c.empty       = empty_c;
    status_c.almost_full = (count >= CNT_W'(DEPTH - AF_SLACK));
    status_c.overflow    = ovf_q;
    status_c.underflow   = unf_q;
  end

  assign data_out    = bypass_c ? data_in : mem[head[ADDR_WIDTH-1:0]];
  assign full        = status_c.full;
  assign empty       = status_c.empty;
  assign almost_full = status_c.almost_full;
  assign overflow    = status_c.overflow;
  assign underflow   = status_c.underflow;

endmodule
